// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/fetch sequencer upstream of branchlogic with call/return stack; ports: clk,rst | mem_addr,mem_data ROM | instr,instr_valid,instr_ready execute | c_flag,z_flag,flags_valid flags | br_addr,br_offset,br_condition,br_result0/c/z branchlogic | pc,halted,stack_err status
module fetch_sequencer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic [7:0]            instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  c_flag,
  input  logic                  z_flag,
  input  logic                  flags_valid,
  output logic [ADDR_WIDTH-1:0] br_addr,
  output logic [7:0]            br_offset,
  output logic [1:0]            br_condition,
  input  logic [ADDR_WIDTH-1:0] br_result0,
  input  logic [ADDR_WIDTH-1:0] br_resultc,
  input  logic [ADDR_WIDTH-1:0] br_resultz,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  stack_err
);
  localparam int AW  = ADDR_WIDTH;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  typedef enum logic [2:0] {FETCH, DECODE, DISPATCH, OFSFETCH, OFSDECODE, RESOLVE, HALT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [7:0]     instr_q, instr_d, off_q, off_d;
  logic [1:0]     op_q, op_d;
  logic           halted_q, halted_d, err_q, err_d, push;
  logic [AW-1:0]  stack_q [STACK_DEPTH];
  logic [IW-1:0]  rd_idx, wr_idx;
  logic           is_br, is_ret, is_halt, stack_full;
  assign rd_idx     = IW'(sp_q - SPW'(1));
  assign wr_idx     = IW'(sp_q);
  assign is_br      = mem_data[7:2] == 6'b111100;
  assign is_ret     = mem_data[7:4] == 4'hE;
  assign is_halt    = mem_data[7:4] == 4'hD;
  assign stack_full = sp_q == SPW'(STACK_DEPTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= AW'(RESET_ADDR);
      sp_q     <= '0;
      instr_q  <= '0;
      off_q    <= '0;
      op_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      instr_q  <= instr_d;
      off_q    <= off_d;
      op_q     <= op_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    else if (push) stack_q[wr_idx] <= pc_q;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    instr_d  = instr_q;
    off_d    = off_q;
    op_d     = op_q;
    halted_d = halted_q;
    err_d    = err_q;
    push     = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE:
        if (is_br) begin
          pc_d    = pc_q + AW'(1);
          op_d    = mem_data[1:0];
          state_d = OFSFETCH;
        end else if (is_ret) begin
          if (sp_q == '0) begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d    = stack_q[rd_idx];
            sp_d    = sp_q - SPW'(1);
            state_d = FETCH;
          end
        end else if (is_halt) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          instr_d = mem_data;
          state_d = DISPATCH;
        end
      DISPATCH:
        if (instr_ready) begin
          pc_d    = pc_q + AW'(1);
          state_d = FETCH;
        end
      OFSFETCH: state_d = OFSDECODE;
      OFSDECODE: begin
        off_d   = mem_data;
        pc_d    = pc_q + AW'(1);
        state_d = RESOLVE;
      end
      RESOLVE:
        if (flags_valid) begin
          if (op_q == 2'd3 && stack_full) begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d    = op_q == 2'd1 ? br_resultc : op_q == 2'd2 ? br_resultz : br_result0;
            push    = op_q == 2'd3;
            sp_d    = push ? sp_q + SPW'(1) : sp_q;
            state_d = FETCH;
          end
        end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    mem_addr     = pc_q;
    pc           = pc_q;
    instr        = instr_q;
    instr_valid  = state_q == DISPATCH;
    br_addr      = pc_q;
    br_offset    = off_q;
    br_condition = {c_flag, z_flag};
    halted       = halted_q;
    stack_err    = err_q;
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized instruction-level check of fetch_sequencer against a ROM/stack reference model
module tb_fetch_sequencer;
  localparam int AW = 9;
  localparam int SD = 4;
  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] mem_addr, br_addr, br_result0, br_resultc, br_resultz, pc;
  logic [7:0] mem_data, instr, br_offset;
  logic [1:0] br_condition;
  logic instr_valid, instr_ready, c_flag, z_flag, flags_valid, halted, stack_err;
  logic [7:0] rom [512];
  int total = 0;
  int bad = 0;
  logic [AW-1:0] mp;
  logic [AW-1:0] stk [$];
  bit mhalt, merr;
  fetch_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_ADDR(0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .c_flag(c_flag), .z_flag(z_flag), .flags_valid(flags_valid),
    .br_addr(br_addr), .br_offset(br_offset), .br_condition(br_condition),
    .br_result0(br_result0), .br_resultc(br_resultc), .br_resultz(br_resultz),
    .pc(pc), .halted(halted), .stack_err(stack_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= rom[mem_addr];
  assign br_result0 = br_addr + {br_offset[7], br_offset} + AW'(br_offset[7]);
  assign br_resultc = br_condition[1] ? br_result0 : br_addr;
  assign br_resultz = br_condition[0] ? br_result0 : br_addr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  function automatic logic [AW-1:0] tgt(input logic [AW-1:0] base, input logic [7:0] off);
    int d;
    d = off[7] ? int'(off) - 256 + 1 : int'(off);
    return AW'(int'(base) + d);
  endfunction
  function automatic logic [7:0] rnd_byte();
    int k;
    logic [7:0] b;
    k = $urandom_range(99);
    if (k < 8) return 8'hF0;
    if (k < 16) return 8'hF1;
    if (k < 24) return 8'hF2;
    if (k < 32) return 8'hF3;
    if (k < 38) return {4'hE, 4'($urandom)};
    if (k < 40) return {4'hD, 4'($urandom)};
    do b = 8'($urandom); while (b[7:4] == 4'hD || b[7:4] == 4'hE || b[7:2] == 6'b111100);
    return b;
  endfunction
  task automatic do_reset;
    rst = 1'b1;
    instr_ready = 1'b0;
    flags_valid = 1'b0;
    tick;
    chk("rst_pc", pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", stack_err, 0);
    rst = 1'b0;
    mp = '0;
    stk.delete();
    mhalt = 1'b0;
    merr = 1'b0;
  endtask
  task automatic clear_rom;
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
  endtask
  task automatic exec_one(input int rdy_low, input int fv_low, input int cz);
    logic [7:0] op, off;
    logic [AW-1:0] p1, base, t;
    logic c, z, r, v;
    int n, lows;
    op = rom[mp];
    p1 = mp + 1;
    base = mp + 2;
    chk("fetch_addr", mem_addr, mp);
    chk("fetch_valid", instr_valid, 0);
    tick;
    chk("dec_valid", instr_valid, 0);
    tick;
    if (op[7:2] == 6'b111100) begin
      chk("ofs_addr", mem_addr, p1);
      tick;
      tick;
      off = rom[p1];
      lows = fv_low < 0 ? int'($urandom_range(3)) : fv_low;
      n = 0;
      do begin
        c = cz < 0 ? 1'($urandom) : cz[1];
        z = cz < 0 ? 1'($urandom) : cz[0];
        v = n >= lows;
        c_flag = c;
        z_flag = z;
        flags_valid = v;
        chk("res_br_addr", br_addr, base);
        chk("res_hold_addr", mem_addr, base);
        chk("res_off", br_offset, off);
        chk("res_valid", instr_valid, 0);
        tick;
        n++;
      end while (!v);
      flags_valid = 1'b0;
      t = tgt(base, off);
      case (op[1:0])
        2'd0: mp = t;
        2'd1: mp = c ? t : base;
        2'd2: mp = z ? t : base;
        default:
          if (stk.size() == SD) begin
            mhalt = 1'b1;
            merr = 1'b1;
            mp = base;
          end else begin
            stk.push_back(base);
            mp = t;
          end
      endcase
    end else if (op[7:4] == 4'hE) begin
      if (stk.size() == 0) begin
        mhalt = 1'b1;
        merr = 1'b1;
      end else mp = stk.pop_back();
    end else if (op[7:4] == 4'hD) mhalt = 1'b1;
    else begin
      lows = rdy_low < 0 ? int'($urandom_range(3)) : rdy_low;
      n = 0;
      do begin
        r = n >= lows;
        instr_ready = r;
        chk("disp_valid", instr_valid, 1);
        chk("disp_instr", instr, op);
        chk("disp_pc", pc, mp);
        tick;
        n++;
      end while (!r);
      instr_ready = 1'b0;
      mp = p1;
    end
    if (mhalt) begin
      chk("halt_flag", halted, 1);
      chk("halt_err", stack_err, merr);
      repeat (3) begin
        tick;
        chk("halt_pc", pc, mp);
        chk("halt_valid", instr_valid, 0);
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    c_flag = 1'b0;
    z_flag = 1'b0;
    flags_valid = 1'b0;
    clear_rom();
    rom[0] = 8'h12;
    rom[1] = 8'h34;
    do_reset();
    exec_one(0, 0, -1);
    chk("t1_pc1", pc, 1);
    exec_one(0, 0, -1);
    chk("t1_pc2", pc, 2);
    do_reset();
    exec_one(4, 0, -1);
    chk("t2_pc", pc, 1);
    clear_rom();
    rom[0] = 8'hF0;
    rom[1] = 8'h0E;
    rom[16] = 8'hF2;
    rom[17] = 8'h05;
    do_reset();
    exec_one(0, 0, -1);
    chk("t3_jmp", pc, 9'h010);
    exec_one(0, 0, 3);
    chk("t3_z1", pc, 9'h017);
    exec_one(0, 0, -1);
    do_reset();
    exec_one(0, 0, -1);
    exec_one(0, 0, 0);
    chk("t3_z0", pc, 9'h012);
    rom[17] = 8'hFE;
    do_reset();
    exec_one(0, 0, -1);
    exec_one(0, 0, 1);
    chk("t3_neg", pc, 9'h011);
    rom[17] = 8'h05;
    do_reset();
    exec_one(0, 0, -1);
    exec_one(0, 6, 1);
    chk("t4_late", pc, 9'h017);
    clear_rom();
    rom[0] = 8'hF0;
    rom[1] = 8'h1E;
    rom[32] = 8'hF3;
    rom[33] = 8'h10;
    rom[50] = 8'hE0;
    rom[34] = 8'hE5;
    do_reset();
    exec_one(0, 0, -1);
    exec_one(0, 0, -1);
    chk("t5_call", pc, 9'h032);
    exec_one(0, 0, -1);
    chk("t5_ret", pc, 9'h022);
    exec_one(0, 0, -1);
    chk("t5_err", stack_err, 1);
    chk("t5_halt", halted, 1);
    chk("t5_pc", pc, 9'h022);
    clear_rom();
    for (int i = 0; i < 5; i++) rom[2 * i] = 8'hF3;
    do_reset();
    repeat (5) exec_one(0, 0, -1);
    chk("t6_ovf_err", stack_err, 1);
    chk("t6_ovf_pc", pc, 9'h00A);
    clear_rom();
    rom[0] = 8'hF0;
    rom[1] = 8'hFC;
    rom[511] = 8'h77;
    do_reset();
    exec_one(0, 0, -1);
    chk("t6_to_1ff", pc, 9'h1FF);
    exec_one(0, 0, -1);
    chk("t6_wrap", pc, 9'h000);
    clear_rom();
    rom[0] = 8'h12;
    rom[1] = 8'h34;
    rom[2] = 8'h56;
    do_reset();
    exec_one(0, 0, -1);
    exec_one(0, 0, -1);
    tick;
    tick;
    chk("t6_pre_valid", instr_valid, 1);
    chk("t6_pre_pc", pc, 2);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", instr_valid, 0);
    chk("t6_async_pc", pc, 0);
    chk("t6_async_instr", instr, 0);
    @(negedge clk);
    rst = 1'b0;
    mp = '0;
    stk.delete();
    mhalt = 1'b0;
    merr = 1'b0;
    exec_one(0, 0, -1);
    repeat (25) begin
      for (int i = 0; i < 512; i++) rom[i] = rnd_byte();
      do_reset();
      for (int k = 0; k < 60 && !mhalt; k++) exec_one(-1, -1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
